// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_shift_tx serializer.
// PISO_PARITY_EN appends an even-parity bit after the data bits of every word.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // The counter must hold values 0..WIDTH-1+PARITY_BITS, plus headroom so it never wraps.
    localparam int CNT_EXTRA = 1 + PARITY_BITS;

    function automatic int count_width(input int width);
        return $clog2(width + CNT_EXTRA);
    endfunction

    function automatic logic parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer.
// It is cleared on load, advanced on each enabled shift, and flags the final bit of the frame.
module piso_bit_counter #(
    parameter int CW   = 4,
    parameter int LAST = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [CW-1:0] LAST_V = CW'(LAST);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == LAST_V);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with a valid/ready load port and a shift-hold enable.
// Build with PISO_PARITY_EN to send an even-parity bit after the last data bit.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW   = count_width(WIDTH);
    localparam int LAST = WIDTH - 1 + PARITY_BITS;
    localparam int SW   = WIDTH + PARITY_BITS;

    state_t r_state;
    state_t w_nextState;

    logic [SW-1:0] r_shift;
    logic          r_sout;
    logic          r_soutValid;
    logic          r_busy;

    logic          w_handshake;
    logic          w_advance;
    logic          w_finish;
    logic          w_tc;
    logic [SW-1:0] w_loadWord;
    logic          w_loadBit;
    logic          w_nextBit;

    // The parity bit rides in the shift register after the data bits, so it falls out naturally.
`ifdef PISO_PARITY_EN
    assign w_loadWord = LSB_FIRST ? {parity(32'(load_data)), load_data}
                                  : {load_data, parity(32'(load_data))};
`else
    assign w_loadWord = load_data;
`endif

    assign w_loadBit = LSB_FIRST ? w_loadWord[0] : w_loadWord[SW-1];
    assign w_nextBit = LSB_FIRST ? r_shift[1]    : r_shift[SW-2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        load_ready  = 1'b0;
        done        = 1'b0;
        w_handshake = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                load_ready  = !rst;
                w_handshake = load_valid && !rst;
                if (w_handshake) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (w_tc) begin
                        done        = !rst;
                        w_finish    = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_sout      <= 1'b0;
            r_soutValid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_handshake) begin
            r_shift     <= w_loadWord;
            r_sout      <= w_loadBit;
            r_soutValid <= 1'b1;
            r_busy      <= 1'b1;
        end else if (w_finish) begin
            r_sout      <= 1'b0;
            r_soutValid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_advance) begin
            r_shift <= LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
            r_sout  <= w_nextBit;
        end
    end

    piso_bit_counter #(
        .CW  (CW),
        .LAST(LAST)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clear(w_handshake),
        .i_inc  (w_advance),
        .o_tc   (w_tc)
    );

    assign sout       = r_sout;
    assign sout_valid = r_soutValid;
    assign busy       = r_busy;

endmodule
